// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding unit.
package hazard_pkg;

    // Load-use stall controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    // Forward select encoding: 0 = register file, k+1 = stage k result.
    localparam int SEL_RF   = 0;
    localparam int SEL_STG0 = 1;

    // Width of one operand's forward select.
    function automatic int sel_width(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_priority_match.sv
// Per-operand forwarding match: compares one ID source register against the
// EX destination and the post-EX stages and returns the select that will be
// correct one cycle later, when every instruction has advanced one stage.
module fwd_priority_match
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = sel_width(NUM_STAGES)
) (
    input  logic                         id_valid_i,
    input  logic                         use_i,
    input  logic [REG_AW-1:0]            rs_i,
    input  logic                         ex_valid_i,
    input  logic                         ex_reg_write_i,
    input  logic [REG_AW-1:0]            ex_rd_i,
    input  logic [NUM_STAGES*REG_AW-1:0] stg_rd_i,
    input  logic [NUM_STAGES-1:0]        stg_reg_write_i,
    output logic [SEL_W-1:0]             sel_o,
    output logic                         match_ex_o
);

    logic                  rs_live;
    logic                  ex_hit;
    logic [NUM_STAGES-1:0] stg_hit;
    logic                  unused_last_hit;

    // x0 is hardwired zero and an unread or invalid operand never matches.
    assign rs_live = id_valid_i & use_i & (rs_i != '0);
    assign ex_hit  = rs_live & ex_valid_i & ex_reg_write_i & (ex_rd_i == rs_i);

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stg_hit
        assign stg_hit[gi] = stg_reg_write_i[gi] &
                             (stg_rd_i[gi*REG_AW +: REG_AW] == rs_i);
    end

    // The last stage retires before the consumer reaches EX; the register
    // file is write-through, so that hit needs no select.
    assign unused_last_hit = stg_hit[NUM_STAGES-1];

    // Oldest-first scan so a younger producer overwrites an older one; EX wins.
    always_comb begin
        sel_o      = SEL_W'(SEL_RF);
        match_ex_o = 1'b0;
        if (rs_live) begin
            for (int k = NUM_STAGES - 2; k >= 0; k--) begin
                if (stg_hit[k]) begin
                    sel_o = SEL_W'(k + 2);
                end
            end
            if (ex_hit) begin
                sel_o      = SEL_W'(SEL_STG0);
                match_ex_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select generation and load-use stall control. Selects are
// computed in ID and registered so they stay stable through the EX cycle.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int REG_AW     = 5,
    parameter  int NUM_STAGES = 2,
    parameter  int LOAD_STALL = 1,
    localparam int SEL_W      = sel_width(NUM_STAGES),
    localparam int CNT_W      = $clog2(LOAD_STALL + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]           id_uses,
    input  logic                         ex_valid,
    input  logic [REG_AW-1:0]            ex_rd,
    input  logic                         ex_reg_write,
    input  logic                         ex_mem_read,
    input  logic [NUM_STAGES*REG_AW-1:0] stg_rd,
    input  logic [NUM_STAGES-1:0]        stg_reg_write,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic                         stall,
    output logic                         bubble
);

    hz_state_e                state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     stall_q;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
    logic [NUM_SRC-1:0]       match_ex;
    logic                     hazard;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_priority_match #(
            .REG_AW     (REG_AW),
            .NUM_STAGES (NUM_STAGES),
            .SEL_W      (SEL_W)
        ) u_match (
            .id_valid_i      (id_valid),
            .use_i           (id_uses[gi]),
            .rs_i            (id_rs[gi*REG_AW +: REG_AW]),
            .ex_valid_i      (ex_valid),
            .ex_reg_write_i  (ex_reg_write),
            .ex_rd_i         (ex_rd),
            .stg_rd_i        (stg_rd),
            .stg_reg_write_i (stg_reg_write),
            .sel_o           (fwd_sel_d[gi*SEL_W +: SEL_W]),
            .match_ex_o      (match_ex[gi])
        );
    end

    // A load in EX feeding any used ID operand cannot be forwarded in time.
    assign hazard = ex_mem_read & (|match_ex);

    // IDLE stalls combinationally on a hazard; STALL holds a registered stall.
    // Flush kills the ID instruction, so it never stalls in that cycle.
    always_comb begin
        stall = 1'b0;
        if (!flush) begin
            stall = stall_q | ((state_q == IDLE) & hazard);
        end
    end

    assign bubble  = stall;
    assign fwd_sel = fwd_sel_q;

    // Stall FSM, countdown and registered forward selects.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            fwd_sel_q <= '0;
        end else begin
            // A bubble enters EX while stalling, so it needs no forwarding.
            fwd_sel_q <= stall ? '0 : fwd_sel_d;
            case (state_q)
                IDLE: begin
                    if (hazard && (LOAD_STALL > 1)) begin
                        state_q <= STALL;
                        cnt_q   <= CNT_W'(LOAD_STALL - 1);
                        stall_q <= 1'b1;
                    end
                end
                STALL: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        stall_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: three configurations driven by one shared stimulus stream.
//   dut 0: NUM_STAGES=2, LOAD_STALL=1
//   dut 1: NUM_STAGES=4, LOAD_STALL=3
//   dut 2: NUM_STAGES=2, LOAD_STALL=3
module tb_hazard_forward_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_uses;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [19:0] stg_rd4;
    logic [3:0]  stg_we4;

    logic [3:0] sel_a;
    logic [5:0] sel_b;
    logic [3:0] sel_c;
    logic       stall_a, stall_b, stall_c;
    logic       bub_a, bub_b, bub_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    dut;
        int    s0;
        int    s1;
        logic  st;
    } exp_t;

    exp_t exp_q[$];

    hazard_forward_unit #(.NUM_SRC(2), .REG_AW(5), .NUM_STAGES(2), .LOAD_STALL(1)) u_a (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
        .id_uses(id_uses), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stg_rd(stg_rd4[9:0]), .stg_reg_write(stg_we4[1:0]),
        .fwd_sel(sel_a), .stall(stall_a), .bubble(bub_a)
    );

    hazard_forward_unit #(.NUM_SRC(2), .REG_AW(5), .NUM_STAGES(4), .LOAD_STALL(3)) u_b (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
        .id_uses(id_uses), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stg_rd(stg_rd4), .stg_reg_write(stg_we4),
        .fwd_sel(sel_b), .stall(stall_b), .bubble(bub_b)
    );

    hazard_forward_unit #(.NUM_SRC(2), .REG_AW(5), .NUM_STAGES(2), .LOAD_STALL(3)) u_c (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
        .id_uses(id_uses), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stg_rd(stg_rd4[9:0]), .stg_reg_write(stg_we4[1:0]),
        .fwd_sel(sel_c), .stall(stall_c), .bubble(bub_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_in();
        flush        = 1'b0;
        reset        = 1'b0;
        id_valid     = 1'b0;
        id_rs        = '0;
        id_uses      = '0;
        ex_valid     = 1'b0;
        ex_rd        = '0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        stg_rd4      = '0;
        stg_we4      = '0;
    endtask

    task automatic ex_in(input logic v, input logic [4:0] rd, input logic we, input logic ld);
        ex_valid     = v;
        ex_rd        = rd;
        ex_reg_write = we;
        ex_mem_read  = ld;
    endtask

    task automatic id_in(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] uses);
        id_valid = v;
        id_rs    = {r1, r0};
        id_uses  = uses;
    endtask

    task automatic stg(input int k, input logic [4:0] rd);
        stg_rd4[k*5 +: 5] = rd;
        stg_we4[k]        = 1'b1;
    endtask

    task automatic push(input string tag, input int d, input int s0, input int s1, input logic st);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.s0  = s0;
        e.s1  = s1;
        e.st  = st;
        exp_q.push_back(e);
    endtask

    task automatic push_all(input string tag, input int s0, input int s1, input logic st);
        for (int d = 0; d < 3; d++) push(tag, d, s0, s1, st);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o0, o1;
        logic        ost, obub;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                0: begin o0 = 32'(sel_a[1:0]); o1 = 32'(sel_a[3:2]); ost = stall_a; obub = bub_a; end
                1: begin o0 = 32'(sel_b[2:0]); o1 = 32'(sel_b[5:3]); ost = stall_b; obub = bub_b; end
                default: begin o0 = 32'(sel_c[1:0]); o1 = 32'(sel_c[3:2]); ost = stall_c; obub = bub_c; end
            endcase
            checks++;
            assert (o0 === 32'(e.s0) && o1 === 32'(e.s1) && ost === e.st && obub === e.st)
            else begin
                errors++;
                $error("FAIL %s dut%0d: got sel0=%0d sel1=%0d stall=%b bubble=%b, want sel0=%0d sel1=%0d stall=%b bubble=%b",
                       e.tag, e.dut, o0, o1, ost, obub, e.s0, e.s1, e.st, e.st);
            end
            $display("check %-20s dut%0d sel0=%0d sel1=%0d stall=%b", e.tag, e.dut, o0, o1, ost);
        end
    endtask

    // Sample away from the active edge, then move to just after the next edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        idle_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_all("reset_state", 0, 0, 1'b0);
        step();

        // ALU producer in EX forwards via sel 1 without stalling.
        idle_in(); ex_in(1, 5, 1, 0); id_in(1, 5, 0, 2'b01);
        push_all("alu_nostall", 0, 0, 1'b0);
        step();
        idle_in();
        push_all("alu_sel1", 1, 0, 1'b0);
        step();

        // Invalid ID instruction never matches nor stalls.
        idle_in(); ex_in(1, 6, 1, 1); id_in(0, 6, 0, 2'b01);
        push_all("idv0_nostall", 0, 0, 1'b0);
        step();
        idle_in();
        push_all("idv0_sel", 0, 0, 1'b0);
        step();

        // Youngest producer wins; then stage matches map to k+2.
        idle_in(); ex_in(1, 7, 1, 0); stg(0, 7); id_in(1, 0, 7, 2'b10);
        push_all("prio_nostall", 0, 0, 1'b0);
        step();
        idle_in(); stg(0, 9); id_in(1, 9, 0, 2'b01);
        push_all("prio_ex_first", 0, 1, 1'b0);
        step();
        idle_in(); stg(1, 9); id_in(1, 9, 0, 2'b01);
        push_all("stg0_sel2", 2, 0, 1'b0);
        step();
        idle_in();
        push("stg1_retired", 0, 0, 0, 1'b0);
        push("stg1_sel3", 1, 3, 0, 1'b0);
        push("stg1_retired", 2, 0, 0, 1'b0);
        step();

        // Load-use on operand 0; load then walks down the stages.
        reset_all();
        idle_in(); ex_in(1, 3, 1, 1); id_in(1, 3, 0, 2'b01);
        push_all("lu_stall", 0, 0, 1'b1);
        step();
        idle_in(); stg(0, 3); id_in(1, 3, 0, 2'b01);
        push("lu1_release", 0, 0, 0, 1'b0);
        push("lu3_hold2", 1, 0, 0, 1'b1);
        push("lu3_hold2", 2, 0, 0, 1'b1);
        step();
        idle_in(); stg(1, 3); id_in(1, 3, 0, 2'b01);
        push("lu1_sel2", 0, 2, 0, 1'b0);
        push("lu3_hold3", 1, 0, 0, 1'b1);
        push("lu3_hold3", 2, 0, 0, 1'b1);
        step();
        idle_in(); stg(2, 3); id_in(1, 3, 0, 2'b01);
        push_all("lu3_release", 0, 0, 1'b0);
        step();
        idle_in();
        push("lu_after", 0, 0, 0, 1'b0);
        push("lu3_sel4", 1, 4, 0, 1'b0);
        push("lu3_rf", 2, 0, 0, 1'b0);
        step();

        // x0 and unused operands never stall.
        idle_in(); ex_in(1, 0, 1, 1); id_in(1, 0, 0, 2'b11);
        push_all("x0_nostall", 0, 0, 1'b0);
        step();
        idle_in(); ex_in(1, 4, 1, 1); id_in(1, 2, 4, 2'b01);
        push_all("x0_sel", 0, 0, 1'b0);
        push_all("unused_nostall", 0, 0, 1'b0);
        step();
        idle_in();
        push_all("unused_sel", 0, 0, 1'b0);
        step();

        // Flush on the second stall cycle.
        reset_all();
        idle_in(); ex_in(1, 4, 1, 1); id_in(1, 2, 4, 2'b10);
        push_all("lu_op1_stall", 0, 0, 1'b1);
        step();
        idle_in(); flush = 1'b1; stg(0, 4); id_in(1, 2, 4, 2'b10);
        push_all("flush_kill", 0, 0, 1'b0);
        step();
        idle_in(); stg(1, 4); id_in(1, 2, 4, 2'b10);
        push_all("post_flush", 0, 0, 1'b0);
        step();
        idle_in();
        push("post_flush_rf", 0, 0, 0, 1'b0);
        push("post_flush_sel3", 1, 0, 3, 1'b0);
        push("post_flush_rf", 2, 0, 0, 1'b0);
        step();

        // Reset while stalling aborts the stall at the next edge.
        idle_in(); ex_in(1, 4, 1, 1); id_in(1, 2, 4, 2'b10);
        push_all("rst_setup", 0, 0, 1'b1);
        step();
        idle_in(); reset = 1'b1; stg(0, 4); id_in(1, 2, 4, 2'b10);
        push("rst_cycle_hold", 1, 0, 0, 1'b1);
        push("rst_cycle_hold", 2, 0, 0, 1'b1);
        step();
        idle_in(); stg(1, 4); id_in(1, 2, 4, 2'b10);
        push_all("rst_clears", 0, 0, 1'b0);
        step();
        idle_in();
        push("rst_resume", 0, 0, 0, 1'b0);
        push("rst_resume_sel3", 1, 0, 3, 1'b0);
        push("rst_resume", 2, 0, 0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
